// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro rate integrator: the state encoding,
// the rate clamp limits and the byte-order fix for the controller words.
package gyro_pkg;

  typedef enum logic {
    CALIB = 1'b0,
    RUN   = 1'b1
  } gyro_state_t;

  localparam logic signed [15:0] RATE_MAX = 16'sh7FFF;
  localparam logic signed [15:0] RATE_MIN = 16'sh8000;

  // The controller hands each word over with its low byte in the upper half.
  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/gyro_rate_integrator_if.sv
// Reader-side port bundle of the gyro rate integrator: results, status and the
// valid/ack handshake, plus the FSM state for observation.
interface gyro_rate_integrator_if #(
  parameter int ACC_W = 32
) ();
  import gyro_pkg::*;

  logic signed [15:0]      rate_x;
  logic signed [15:0]      rate_y;
  logic signed [15:0]      rate_z;
  logic signed [ACC_W-1:0] angle_x;
  logic signed [ACC_W-1:0] angle_y;
  logic signed [ACC_W-1:0] angle_z;
  logic                    cal_done;
  logic                    data_valid;
  logic                    overrun;
  logic                    data_ack;
  gyro_state_t             dbg_state;

  // Handshake: data_valid rises on the cycle a new result lands in the angle
  // registers and holds until the reader returns a one-cycle data_ack while it
  // is high. An ack with data_valid low has no effect. A new result landing
  // while data_valid is high and not acknowledged that cycle sets the sticky
  // overrun flag and replaces the data.
  modport master (
    output rate_x, rate_y, rate_z,
    output angle_x, angle_y, angle_z,
    output cal_done, data_valid, overrun, dbg_state,
    input  data_ack
  );

  modport slave (
    input  rate_x, rate_y, rate_z,
    input  angle_x, angle_y, angle_z,
    input  cal_done, data_valid, overrun, dbg_state,
    output data_ack
  );

endinterface

// File: rtl/gyro_axis_path.sv
// One gyro axis: calibration sum and bias, bias-removed saturated rate
// (stage 1) and the wrapping angle accumulator (stage 2).
module gyro_axis_path
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2 = 4,
  parameter int ACC_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    cal_acc,
  input  logic                    cal_fin,
  input  logic                    s1_go,
  input  logic                    s2_go,
  input  logic signed [15:0]      sample,
  output logic signed [15:0]      rate,
  output logic signed [ACC_W-1:0] angle
);

  localparam int SW = 16 + CAL_LOG2;

  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_nxt;
  logic signed [15:0]   bias_q;
  logic signed [16:0]   diff;
  logic signed [15:0]   rate_nxt;

  // The sum including the current sample feeds the bias on the final strobe.
  assign sum_nxt = sum_q + SW'(sample);
  assign diff    = 17'(sample) - 17'(bias_q);

  always_comb begin
    rate_nxt = diff[15:0];
    if (diff > 17'sd32767)
      rate_nxt = RATE_MAX;
    else if (diff < -17'sd32768)
      rate_nxt = RATE_MIN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q  <= '0;
      bias_q <= '0;
      rate   <= '0;
      angle  <= '0;
    end else if (clr) begin
      sum_q  <= '0;
      bias_q <= '0;
      rate   <= '0;
      angle  <= '0;
    end else begin
      if (cal_fin) begin
        bias_q <= 16'(sum_nxt >>> CAL_LOG2);
        sum_q  <= '0;
      end else if (cal_acc) begin
        sum_q <= sum_nxt;
      end
      if (s1_go)
        rate <= rate_nxt;
      if (s2_go)
        angle <= angle + ACC_W'(rate);
    end
  end

endmodule

// File: rtl/gyro_rate_integrator.sv
// Gyro rate integrator: strobe detect on the controller's read-enable level,
// start-up bias calibration, per-axis rate/angle paths and reader handshake.
module gyro_rate_integrator
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2 = 4,
  parameter int ACC_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           gyro_x,
  input  logic [15:0]           gyro_y,
  input  logic [15:0]           gyro_z,
  input  logic                  arm_read_enable_g,
  input  logic                  cal_start,
  gyro_rate_integrator_if.master rd
);

  gyro_state_t         state_q, state_d;
  logic                en_d;
  logic                s1_q;
  logic                dv_q;
  logic                ovr_q;
  logic [CAL_LOG2-1:0] cal_cnt_q;

  logic strobe, cal_acc, cal_fin, s1_go, s2_go;

  // cal_start overrides every sample or completion in the same cycle.
  assign strobe  = arm_read_enable_g & ~en_d;
  assign cal_acc = (state_q == CALIB) & strobe & ~cal_start;
  assign cal_fin = cal_acc & (&cal_cnt_q);
  assign s1_go   = (state_q == RUN) & strobe & ~cal_start;
  assign s2_go   = s1_q & ~cal_start;

  always_comb begin
    state_d = state_q;
    if (cal_start)
      state_d = CALIB;
    else if (cal_fin)
      state_d = RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CALIB;
      en_d      <= 1'b0;
      s1_q      <= 1'b0;
      dv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      cal_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      en_d    <= arm_read_enable_g;
      s1_q    <= s1_go;
      if (cal_start || cal_fin)
        cal_cnt_q <= '0;
      else if (cal_acc)
        cal_cnt_q <= cal_cnt_q + 1'b1;
      if (cal_start)
        dv_q <= 1'b0;
      else if (s2_go)
        dv_q <= 1'b1;
      else if (rd.data_ack)
        dv_q <= 1'b0;
      if (cal_start)
        ovr_q <= 1'b0;
      else if (s2_go && dv_q && !rd.data_ack)
        ovr_q <= 1'b1;
    end
  end

  assign rd.cal_done   = (state_q == RUN);
  assign rd.data_valid = dv_q;
  assign rd.overrun    = ovr_q;
  assign rd.dbg_state  = state_q;

  gyro_axis_path #(.CAL_LOG2(CAL_LOG2), .ACC_W(ACC_W)) u_axis_x (
    .clk(clk), .reset_n(reset_n), .clr(cal_start), .cal_acc(cal_acc), .cal_fin(cal_fin),
    .s1_go(s1_go), .s2_go(s2_go), .sample(signed'(swap_bytes(gyro_x))),
    .rate(rd.rate_x), .angle(rd.angle_x)
  );

  gyro_axis_path #(.CAL_LOG2(CAL_LOG2), .ACC_W(ACC_W)) u_axis_y (
    .clk(clk), .reset_n(reset_n), .clr(cal_start), .cal_acc(cal_acc), .cal_fin(cal_fin),
    .s1_go(s1_go), .s2_go(s2_go), .sample(signed'(swap_bytes(gyro_y))),
    .rate(rd.rate_y), .angle(rd.angle_y)
  );

  gyro_axis_path #(.CAL_LOG2(CAL_LOG2), .ACC_W(ACC_W)) u_axis_z (
    .clk(clk), .reset_n(reset_n), .clr(cal_start), .cal_acc(cal_acc), .cal_fin(cal_fin),
    .s1_go(s1_go), .s2_go(s2_go), .sample(signed'(swap_bytes(gyro_z))),
    .rate(rd.rate_z), .angle(rd.angle_z)
  );

endmodule

// File: tb/tb_gyro_rate_integrator.sv
// Bench for gyro_rate_integrator: directed calibration/saturation/handshake
// cases, then random traffic, all compared each cycle to an integer model.
module tb_gyro_rate_integrator;
  import gyro_pkg::*;

  localparam int CAL_LOG2 = 2;
  localparam int ACC_W    = 17;
  localparam int CAL_N    = 1 << CAL_LOG2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] gx = '0, gy = '0, gz = '0;
  logic        arm = 1'b0;
  logic        cal_start = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  gyro_rate_integrator_if #(.ACC_W(ACC_W)) rd ();

  gyro_rate_integrator #(.CAL_LOG2(CAL_LOG2), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .gyro_x(gx),
    .gyro_y(gy),
    .gyro_z(gz),
    .arm_read_enable_g(arm),
    .cal_start(cal_start),
    .rd(rd)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_sum[3], m_bias[3], m_rate[3], m_cnt;
  longint m_angle[3];
  bit     m_run, m_valid, m_ovr, m_pend, m_prev;
  int     smp[3];
  bit     stb;

  function automatic int word_value(input logic [15:0] w);
    int v;
    v = int'(w & 16'h00FF) * 256 + int'(w >> 8);
    if (v >= 32768) v -= 65536;
    return v;
  endfunction

  function automatic int floor_div(input int a, input int n);
    if (a >= 0) return a / n;
    return -((-a + n - 1) / n);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = longint'(1) << ACC_W;
    if (v >= m / 2) v -= m;
    else if (v < -(m / 2)) v += m;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_bias[i] = 0; m_rate[i] = 0; m_angle[i] = 0;
    end
    m_cnt = 0; m_run = 0; m_valid = 0; m_ovr = 0; m_pend = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
      m_prev = 0;
    end else begin
      stb    = arm && !m_prev;
      m_prev = arm;
      smp[0] = word_value(gx);
      smp[1] = word_value(gy);
      smp[2] = word_value(gz);
      if (cal_start) begin
        model_clear();
      end else begin
        if (m_pend) begin
          for (int i = 0; i < 3; i++) m_angle[i] = wrap_acc(m_angle[i] + m_rate[i]);
          if (m_valid && !rd.data_ack) m_ovr = 1;
          m_valid = 1;
          m_pend  = 0;
        end else if (rd.data_ack) begin
          m_valid = 0;
        end
        if (stb) begin
          if (!m_run) begin
            for (int i = 0; i < 3; i++) m_sum[i] += smp[i];
            m_cnt++;
            if (m_cnt == CAL_N) begin
              for (int i = 0; i < 3; i++) m_bias[i] = floor_div(m_sum[i], CAL_N);
              m_run = 1;
            end
          end else begin
            for (int i = 0; i < 3; i++) m_rate[i] = clamp16(smp[i] - m_bias[i]);
            m_pend = 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("rate_x", rd.rate_x, m_rate[0]);
    check("rate_y", rd.rate_y, m_rate[1]);
    check("rate_z", rd.rate_z, m_rate[2]);
    check("angle_x", rd.angle_x, m_angle[0]);
    check("angle_y", rd.angle_y, m_angle[1]);
    check("angle_z", rd.angle_z, m_angle[2]);
    check("cal_done", rd.cal_done, m_run);
    check("data_valid", rd.data_valid, m_valid);
    check("overrun", rd.overrun, m_ovr);
    check("dbg_state", longint'(rd.dbg_state), m_run);
  end

  // ---------------- driver tasks ----------------
  task automatic do_strobe(input logic [15:0] x, y, z, input bit ack_s2);
    @(negedge clk);
    gx = x; gy = y; gz = z; arm = 1'b1;
    @(negedge clk);
    if (ack_s2) rd.data_ack = 1'b1;
    @(negedge clk);
    rd.data_ack = 1'b0;
    arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    rd.data_ack = 1'b1;
    @(negedge clk);
    rd.data_ack = 1'b0;
  endtask

  task automatic cal_pulse(input bit with_strobe);
    @(negedge clk);
    cal_start = 1'b1;
    if (with_strobe) begin
      gx = 16'(($urandom)); arm = 1'b1;
    end
    @(negedge clk);
    cal_start = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rate_x"}, rd.rate_x, 0);
    check({tag, "_angle_x"}, rd.angle_x, 0);
    check({tag, "_angle_z"}, rd.angle_z, 0);
    check({tag, "_cal_done"}, rd.cal_done, 0);
    check({tag, "_valid"}, rd.data_valid, 0);
    check({tag, "_overrun"}, rd.overrun, 0);
  endtask

  // Assert reset a few ns after a rising edge and release on the next falling one.
  task automatic reset_async(input string tag);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rd.data_ack = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Calibrate x=10, y=20, z=-5, then two results without ack.
    repeat (CAL_N) do_strobe(16'h0A00, 16'h1400, 16'hFBFF, 1'b0);
    check("cal1_done", rd.cal_done, 1);
    check("cal1_valid", rd.data_valid, 0);
    do_strobe(16'h1E00, 16'h1400, 16'hFBFF, 1'b0);
    check("first_rate_x", rd.rate_x, 20);
    check("first_angle_x", rd.angle_x, 20);
    check("first_valid", rd.data_valid, 1);
    check("first_overrun", rd.overrun, 0);
    do_strobe(16'h1E00, 16'h1400, 16'hFBFF, 1'b0);
    check("second_angle_x", rd.angle_x, 40);
    check("second_overrun", rd.overrun, 1);
    ack_pulse();
    check("ack_valid", rd.data_valid, 0);
    check("ack_overrun", rd.overrun, 1);
    do_strobe(16'h0000, 16'h0100, 16'h0200, 1'b0);
    do_strobe(16'h0000, 16'h0100, 16'h0200, 1'b1);
    check("ack_s2_valid", rd.data_valid, 1);

    // Positive saturation and accumulator wrap.
    cal_pulse(1'b0);
    repeat (CAL_N) do_strobe(16'hF6FF, 16'hF6FF, 16'hF6FF, 1'b0);
    do_strobe(16'hFF7F, 16'hFF7F, 16'h0000, 1'b0);
    check("possat_rate_x", rd.rate_x, 32767);
    check("possat_angle_x", rd.angle_x, 32767);
    do_strobe(16'hFF7F, 16'hFF7F, 16'h0000, 1'b1);
    check("ack_s2_valid2", rd.data_valid, 1);
    check("ack_s2_overrun", rd.overrun, 0);
    do_strobe(16'hFF7F, 16'hFF7F, 16'h0000, 1'b0);
    check("wrap_angle_x", rd.angle_x, -32771);
    check("wrap_overrun", rd.overrun, 1);

    // Negative saturation.
    cal_pulse(1'b0);
    repeat (CAL_N) do_strobe(16'h0A00, 16'h0A00, 16'h0A00, 1'b0);
    do_strobe(16'h0080, 16'h0080, 16'h0A00, 1'b0);
    check("negsat_rate_x", rd.rate_x, -32768);
    check("negsat_angle_x", rd.angle_x, -32768);

    // cal_start with a simultaneous strobe, then a floor-rounded bias.
    cal_pulse(1'b1);
    check_all_zero("calstart");
    do_strobe(16'h0A00, 16'hFFFF, 16'h0000, 1'b0);
    do_strobe(16'h0B00, 16'hFEFF, 16'h0000, 1'b0);
    do_strobe(16'h0C00, 16'hFEFF, 16'h0000, 1'b0);
    check("recal_not_done", rd.cal_done, 0);
    do_strobe(16'h0E00, 16'hFEFF, 16'h0000, 1'b0);
    check("recal_done", rd.cal_done, 1);
    do_strobe(16'h1E00, 16'h0000, 16'h0000, 1'b0);
    check("floor_rate_x", rd.rate_x, 19);
    check("floor_rate_y", rd.rate_y, 2);

    // Reset in the middle of calibration.
    cal_pulse(1'b0);
    repeat (2) do_strobe(16'h0300, 16'h0300, 16'h0300, 1'b0);
    reset_async("rst_cal");
    repeat (CAL_N - 1) do_strobe(16'h0500, 16'h0500, 16'h0500, 1'b0);
    check("rst_cal_not_done", rd.cal_done, 0);
    do_strobe(16'h0500, 16'h0500, 16'h0500, 1'b0);
    check("rst_cal_done", rd.cal_done, 1);

    // Reset between stage 1 and stage 2, with the enable level held high
    // across release so it counts as the first new calibration sample.
    @(negedge clk);
    gx = 16'h6400; gy = 16'h6400; gz = 16'h6400; arm = 1'b1;
    reset_async("rst_pipe");
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("rst_pipe_not_done", rd.cal_done, 0);
    repeat (CAL_N - 1) do_strobe(16'h6400, 16'h6400, 16'h6400, 1'b0);
    check("rst_pipe_done", rd.cal_done, 1);
    do_strobe(16'h6E00, 16'h6400, 16'h6400, 1'b0);
    check("rst_pipe_rate_x", rd.rate_x, 10);
    check("rst_pipe_angle_x", rd.angle_x, 10);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)
        cal_pulse(1'($urandom_range(0, 1)));
      else if (r < 5)
        ack_pulse();
      else
        do_strobe(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
